// File: rtl/motor_cmd_uart.sv
// motor_cmd_uart
//   Receives 8N1 bytes on a 2-flop synchronised rx line and parses 4-byte
//   command frames {SYNC_BYTE, speed A, speed B, checksum}. The checksum is
//   (SYNC_BYTE + A + B) mod 256. A frame with a correct checksum updates
//   the signed speed outputs and toggles aliveStrobe for the motor driver's
//   watchdog.
//
// Ports
//   clk_16mhz   in   sole clock, rising edge
//   rst         in   asynchronous active-high reset
//   rx          in   asynchronous serial input, idle high
//   speedA      out  signed speed of motor A from the last accepted frame
//   speedB      out  signed speed of motor B from the last accepted frame
//   aliveStrobe out  toggles once per accepted frame
//   frame_ok    out  1-cycle pulse when a frame is accepted
//   crc_err     out  1-cycle pulse on a checksum mismatch
//   frame_err   out  1-cycle pulse on a bad stop bit or intra-frame timeout
module motor_cmd_uart #(
    parameter int          CLKS_PER_BIT = 139,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int          TIMEOUT_CLKS = 16000
) (
    input  logic              clk_16mhz,
    input  logic              rst,
    input  logic              rx,
    output logic signed [7:0] speedA,
    output logic signed [7:0] speedB,
    output logic              aliveStrobe,
    output logic              frame_ok,
    output logic              crc_err,
    output logic              frame_err
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int TO_W   = $clog2(TIMEOUT_CLKS + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'((CLKS_PER_BIT / 2) - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {
        U_IDLE  = 2'd0,
        U_START = 2'd1,
        U_DATA  = 2'd2,
        U_STOP  = 2'd3
    } uart_state_e;

    typedef enum logic [1:0] {
        P_HUNT    = 2'd0,
        P_GET_A   = 2'd1,
        P_GET_B   = 2'd2,
        P_GET_SUM = 2'd3
    } parse_state_e;

    // Frame checksum: plain 8-bit wrap-around sum of header and both speeds.
    function automatic logic [7:0] frame_sum(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] s;
        s = SYNC_BYTE + a + b;
        return s;
    endfunction

    // ------------------------------------------------------------------
    // rx synchroniser (resets to the idle-high line level)
    // ------------------------------------------------------------------
    logic rx_meta_q;
    logic rx_sync_q;

    always_ff @(posedge clk_16mhz or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------
    uart_state_e       u_state_q, u_state_d;
    logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              byte_valid_q, byte_valid_d;
    logic              uart_ferr_q, uart_ferr_d;

    logic baud_last;
    logic half_last;

    assign baud_last = (baud_cnt_q == BAUD_LAST);
    assign half_last = (baud_cnt_q == HALF_LAST);

    always_ff @(posedge clk_16mhz or posedge rst) begin
        if (rst) begin
            u_state_q <= U_IDLE;
        end else begin
            u_state_q <= u_state_d;
        end
    end

    always_comb begin
        u_state_d = u_state_q;
        case (u_state_q)
            U_IDLE:  if (!rx_sync_q) u_state_d = U_START;
            // A start bit that is high again at its midpoint was a glitch.
            U_START: if (half_last) u_state_d = rx_sync_q ? U_IDLE : U_DATA;
            U_DATA:  if (baud_last && (bit_cnt_q == 3'd7)) u_state_d = U_STOP;
            // Leave at the stop-bit midpoint so a following start edge is seen.
            U_STOP:  if (baud_last) u_state_d = U_IDLE;
            default: u_state_d = U_IDLE;
        endcase
    end

    always_comb begin
        baud_cnt_d   = baud_cnt_q + 1'b1;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        uart_ferr_d  = 1'b0;
        case (u_state_q)
            U_IDLE: begin
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
            end
            U_START: begin
                if (half_last) baud_cnt_d = '0;
            end
            U_DATA: begin
                if (baud_last) begin
                    baud_cnt_d = '0;
                    shift_d    = {rx_sync_q, shift_q[7:1]};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                end
            end
            U_STOP: begin
                if (baud_last) begin
                    baud_cnt_d   = '0;
                    byte_valid_d = rx_sync_q;
                    uart_ferr_d  = ~rx_sync_q;
                end
            end
            default: baud_cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk_16mhz or posedge rst) begin
        if (rst) begin
            baud_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            byte_valid_q <= 1'b0;
            uart_ferr_q  <= 1'b0;
        end else begin
            baud_cnt_q   <= baud_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_valid_q <= byte_valid_d;
            uart_ferr_q  <= uart_ferr_d;
        end
    end

    // Shift register holds the received byte while byte_valid is high.
    always_ff @(posedge clk_16mhz) begin
        shift_q <= shift_d;
    end

    // ------------------------------------------------------------------
    // Frame parser
    // ------------------------------------------------------------------
    parse_state_e      p_state_q, p_state_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [7:0]        tmpA_q, tmpA_d;
    logic [7:0]        tmpB_q, tmpB_d;
    logic signed [7:0] speedA_q, speedA_d;
    logic signed [7:0] speedB_q, speedB_d;
    logic              alive_q, alive_d;
    logic              frame_ok_q, frame_ok_d;
    logic              crc_err_q, crc_err_d;
    logic              frame_err_q, frame_err_d;

    logic timeout;
    logic sum_match;

    // A byte_valid in the same cycle always wins over the timeout.
    assign timeout   = (p_state_q != P_HUNT) && !byte_valid_q && (to_cnt_q == TO_LAST);
    assign sum_match = (frame_sum(tmpA_q, tmpB_q) == shift_q);

    always_ff @(posedge clk_16mhz or posedge rst) begin
        if (rst) begin
            p_state_q <= P_HUNT;
        end else begin
            p_state_q <= p_state_d;
        end
    end

    always_comb begin
        p_state_d = p_state_q;
        if (uart_ferr_q || timeout) begin
            p_state_d = P_HUNT;
        end else if (byte_valid_q) begin
            case (p_state_q)
                P_HUNT:    if (shift_q == SYNC_BYTE) p_state_d = P_GET_A;
                P_GET_A:   p_state_d = P_GET_B;
                P_GET_B:   p_state_d = P_GET_SUM;
                P_GET_SUM: p_state_d = P_HUNT;
                default:   p_state_d = P_HUNT;
            endcase
        end
    end

    always_comb begin
        tmpA_d      = tmpA_q;
        tmpB_d      = tmpB_q;
        speedA_d    = speedA_q;
        speedB_d    = speedB_q;
        alive_d     = alive_q;
        frame_ok_d  = 1'b0;
        crc_err_d   = 1'b0;
        // Framing error and timeout share one pulse when coincident.
        frame_err_d = uart_ferr_q | timeout;

        if ((p_state_q == P_HUNT) || byte_valid_q || timeout) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        if (byte_valid_q) begin
            case (p_state_q)
                P_GET_A: tmpA_d = shift_q;
                P_GET_B: tmpB_d = shift_q;
                P_GET_SUM: begin
                    if (sum_match) begin
                        speedA_d   = $signed(tmpA_q);
                        speedB_d   = $signed(tmpB_q);
                        alive_d    = ~alive_q;
                        frame_ok_d = 1'b1;
                    end else begin
                        crc_err_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_16mhz or posedge rst) begin
        if (rst) begin
            to_cnt_q    <= '0;
            speedA_q    <= '0;
            speedB_q    <= '0;
            alive_q     <= 1'b0;
            frame_ok_q  <= 1'b0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            to_cnt_q    <= to_cnt_d;
            speedA_q    <= speedA_d;
            speedB_q    <= speedB_d;
            alive_q     <= alive_d;
            frame_ok_q  <= frame_ok_d;
            crc_err_q   <= crc_err_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Partial frame bytes; only meaningful once the matching state is reached.
    always_ff @(posedge clk_16mhz) begin
        tmpA_q <= tmpA_d;
        tmpB_q <= tmpB_d;
    end

    assign speedA      = speedA_q;
    assign speedB      = speedB_q;
    assign aliveStrobe = alive_q;
    assign frame_ok    = frame_ok_q;
    assign crc_err     = crc_err_q;
    assign frame_err   = frame_err_q;

endmodule
